// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared state/class types, flag bit positions and format helpers
package fp_mul_pkg;
  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;
  typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN} fp_class_t;
  localparam int FLAG_INV = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic logic [63:0] qnan(input int exp_w, input int man_w, input bit pay);
    logic [63:0] e_ones;
    e_ones = (64'd1 << exp_w) - 64'd1;
    return (e_ones << man_w) | (pay ? (64'd1 << (man_w - 1)) : 64'd1);
  endfunction
endpackage

// File: rtl/fp_mul_param_round.sv
// fp_round_rne: round-to-nearest-even of a normalised significand, with FTZ and overflow to inf
module fp_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0]        frac,
  input  logic                    g,
  input  logic                    r,
  input  logic                    s,
  input  logic signed [EXP_W+1:0] exp_in,
  output logic [EXP_W-1:0]        exp_out,
  output logic [MAN_W-1:0]        frac_out,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    inexact
);
  logic inc;
  logic carry;
  logic [MAN_W-1:0] frac_inc;
  logic signed [EXP_W+1:0] exp_rnd;
  // a carry out of the fraction leaves it all-zero, so only the exponent needs bumping
  always_comb begin
    inc = g & (r | s | frac[0]);
    {carry, frac_inc} = {1'b0, frac} + (MAN_W+1)'(inc);
    exp_rnd = exp_in + (EXP_W+2)'(carry);
    overflow = !exp_rnd[EXP_W+1] && (exp_rnd[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});
    underflow = exp_rnd[EXP_W+1] || (exp_rnd == '0);
    inexact = g | r | s | overflow | underflow;
    exp_out = overflow ? '1 : underflow ? '0 : exp_rnd[EXP_W-1:0];
    frac_out = (overflow | underflow) ? '0 : frac_inc;
  end
endmodule

// File: rtl/fp_mul_param.sv
// fp_mul_param: multi-cycle IEEE-754 multiplier (DAZ/FTZ, RNE) with valid/ready operand and result ports
module fp_mul_param
  import fp_mul_pkg::*;
#(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter bit QNAN_PAY = 1'b1
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic [3:0]             flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW2 = EXP_W + 2;
  localparam logic [W-1:0] QNAN = W'(qnan(EXP_W, MAN_W, QNAN_PAY));
  localparam logic signed [EW2-1:0] BIAS = EW2'(bias(EXP_W));
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, product_q, product_d, sp_product;
  logic sign_q, sign_d, out_valid_q, out_valid_d;
  logic signed [EW2-1:0] exp_q, exp_d;
  logic [PW-1:0] mprod_q, mprod_d;
  logic [MAN_W-1:0] frac_q, frac_d, rnd_frac;
  logic [2:0] grs_q, grs_d;
  logic [3:0] flags_q, flags_d, sp_flags;
  logic [EXP_W-1:0] rnd_exp;
  logic rnd_ovf, rnd_unf, rnd_inx, top;
  fp_class_t ca, cb;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, bad_mul, special;
  function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    return (e == '0) ? ((f == '0) ? CLS_ZERO : CLS_SUB) :
           (e == '1) ? ((f == '0) ? CLS_INF : (f[MAN_W-1] ? CLS_QNAN : CLS_SNAN)) : CLS_NORM;
  endfunction
  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .frac(frac_q), .g(grs_q[2]), .r(grs_q[1]), .s(grs_q[0]), .exp_in(exp_q),
    .exp_out(rnd_exp), .frac_out(rnd_frac),
    .overflow(rnd_ovf), .underflow(rnd_unf), .inexact(rnd_inx)
  );
  // classify captured operands; subnormals count as zero, specials resolve without the datapath
  always_comb begin
    ca = classify(a_q[W-2:MAN_W], a_q[MAN_W-1:0]);
    cb = classify(b_q[W-2:MAN_W], b_q[MAN_W-1:0]);
    zero_a = (ca == CLS_ZERO) || (ca == CLS_SUB);
    zero_b = (cb == CLS_ZERO) || (cb == CLS_SUB);
    inf_a = ca == CLS_INF;
    inf_b = cb == CLS_INF;
    nan_a = (ca == CLS_QNAN) || (ca == CLS_SNAN);
    nan_b = (cb == CLS_QNAN) || (cb == CLS_SNAN);
    bad_mul = (zero_a && inf_b) || (inf_a && zero_b);
    special = zero_a || zero_b || inf_a || inf_b || nan_a || nan_b;
    sp_product = (nan_a || nan_b || bad_mul) ? QNAN :
                 (inf_a || inf_b) ? {a_q[W-1] ^ b_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                 {a_q[W-1] ^ b_q[W-1], {(W-1){1'b0}}};
    sp_flags = '0;
    sp_flags[FLAG_INV] = bad_mul || (ca == CLS_SNAN) || (cb == CLS_SNAN);
    top = mprod_q[PW-1];
  end
  // next-state and datapath: one stage of work per state
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sign_d = sign_q;
    exp_d = exp_q;
    mprod_d = mprod_q;
    frac_d = frac_q;
    grs_d = grs_q;
    out_valid_d = out_valid_q;
    product_d = product_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        state_d = UNPACK;
      end
      UNPACK: begin
        sign_d = a_q[W-1] ^ b_q[W-1];
        state_d = special ? DONE : MULT;
        out_valid_d = special;
        product_d = special ? sp_product : product_q;
        flags_d = special ? sp_flags : flags_q;
      end
      MULT: begin
        mprod_d = PW'({1'b1, a_q[MAN_W-1:0]}) * PW'({1'b1, b_q[MAN_W-1:0]});
        exp_d = EW2'(a_q[W-2:MAN_W]) + EW2'(b_q[W-2:MAN_W]) - BIAS;
        state_d = NORM;
      end
      NORM: begin
        frac_d = top ? mprod_q[PW-2:MAN_W+1] : mprod_q[PW-3:MAN_W];
        grs_d[2] = top ? mprod_q[MAN_W] : mprod_q[MAN_W-1];
        grs_d[1] = top ? mprod_q[MAN_W-1] : mprod_q[MAN_W-2];
        grs_d[0] = top ? |mprod_q[MAN_W-2:0] : |mprod_q[MAN_W-3:0];
        exp_d = exp_q + EW2'(top);
        state_d = ROUND;
      end
      ROUND: begin
        product_d = {sign_q, rnd_exp, rnd_frac};
        flags_d = '0;
        flags_d[FLAG_OVF] = rnd_ovf;
        flags_d[FLAG_UNF] = rnd_unf;
        flags_d[FLAG_INX] = rnd_inx;
        out_valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sign_q <= 1'b0;
      exp_q <= '0;
      mprod_q <= '0;
      frac_q <= '0;
      grs_q <= '0;
      out_valid_q <= 1'b0;
      product_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      mprod_q <= mprod_d;
      frac_q <= frac_d;
      grs_q <= grs_d;
      out_valid_q <= out_valid_d;
      product_q <= product_d;
      flags_q <= flags_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign product = product_q;
  assign flags = flags_q;
endmodule
